seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_pkg.sv | 21 ++
 rtl/seg_scan_ctrl_sevenseg.sv | 40 ++++
 rtl/seg_scan_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | Package : seg_pkg                                                    |
// | Shared scan-state encoding and segment constants for seg_scan_ctrl.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package seg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } scan_state_e;

  localparam int         NIBBLE_W = 4;
  localparam logic [6:0] SEG_OFF  = 7'b0;

endpackage

`default_nettype wire

// File: rtl/seg_scan_ctrl_sevenseg.sv
// +----------------------------------------------------------------------+
// | Module  : sevenseg                                                   |
// | Hex nibble to active-high segments, bit order {g,f,e,d,c,b,a}.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sevenseg
  import seg_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble_i,
  output logic [6:0]          seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    unique case (nibble_i)
      4'h0:    seg_o = 7'h3F;
      4'h1:    seg_o = 7'h06;
      4'h2:    seg_o = 7'h5B;
      4'h3:    seg_o = 7'h4F;
      4'h4:    seg_o = 7'h66;
      4'h5:    seg_o = 7'h6D;
      4'h6:    seg_o = 7'h7D;
      4'h7:    seg_o = 7'h07;
      4'h8:    seg_o = 7'h7F;
      4'h9:    seg_o = 7'h6F;
      4'hA:    seg_o = 7'h77;
      4'hB:    seg_o = 7'h7C;
      4'hC:    seg_o = 7'h39;
      4'hD:    seg_o = 7'h5E;
      4'hE:    seg_o = 7'h79;
      4'hF:    seg_o = 7'h71;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// +----------------------------------------------------------------------+
// | Module  : seg_scan_ctrl                                              |
// | Multiplexed 7-segment scanner with shadow/active display registers   |
// | and a blanking gap between digits. Optional feature macro:           |
// | SEG_LEADING_ZERO_BLANK_EN (suppresses leading-zero digits).          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_COUNT  = 50000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] wr_data,
  output logic [6:0]                     seg,
  output logic [NUM_DIGITS-1:0]          digit_en,
  output logic                           frame_done
);

  localparam int c_data_w = NIBBLE_W * NUM_DIGITS;
  localparam int c_cnt_w  = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
  localparam int c_idx_w  = $clog2(NUM_DIGITS);

  localparam logic [c_cnt_w-1:0]    c_cnt_max  = c_cnt_w'(DIV_COUNT - 1);
  localparam logic [c_cnt_w-1:0]    c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_idx_w-1:0]    c_idx_last = c_idx_w'(NUM_DIGITS - 1);
  localparam logic [c_idx_w-1:0]    c_idx_one  = c_idx_w'(1);
  localparam logic [NUM_DIGITS-1:0] c_sel_one  = NUM_DIGITS'(1);

  scan_state_e             state_q, state_d;
  logic [c_cnt_w-1:0]      cnt_q, cnt_d;
  logic [c_idx_w-1:0]      idx_q, idx_d;
  logic [c_data_w-1:0]     shadow_q, shadow_d;
  logic [c_data_w-1:0]     active_q, active_d;
  logic                    pending_q, pending_d;
  logic                    active_valid_q, active_valid_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;

  logic                    w_tick;
  logic                    w_accept;
  logic                    w_xfer;
  logic                    w_show;
  logic [6:0]              w_dec;
  logic [NIBBLE_W-1:0]     w_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_blank;

  assign w_tick     = (cnt_q == c_cnt_max);
  assign w_accept   = wr_valid && !pending_q;
  assign wr_ready   = !pending_q;
  assign frame_done = en && w_tick && (state_q == GAP) && (idx_q == c_idx_last);
  assign seg        = seg_q;
  assign digit_en   = digit_en_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    shadow_d       = shadow_q;
    active_d       = active_q;
    pending_d      = pending_q;
    active_valid_d = active_valid_q;
    w_xfer         = 1'b0;

    if (w_accept) begin
      shadow_d  = wr_data;
      pending_d = 1'b1;
    end

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      cnt_d = w_tick ? '0 : cnt_q + c_cnt_one;
      if (w_tick) begin
        unique case (state_q)
          IDLE: begin
            if (pending_q || active_valid_q) begin
              state_d = ON;
              idx_d   = '0;
              w_xfer  = pending_q;
            end
          end
          ON: state_d = GAP;
          GAP: begin
            state_d = ON;
            if (idx_q == c_idx_last) begin
              idx_d  = '0;
              w_xfer = pending_q;
            end else begin
              idx_d = idx_q + c_idx_one;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    // Transfer and accept are mutually exclusive: accept needs pending=0.
    if (w_xfer) begin
      active_d       = shadow_q;
      pending_d      = 1'b0;
      active_valid_d = 1'b1;
    end
  end

  // Outputs are decoded from next-state values so the registered drive
  // lines up with the state it belongs to.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign w_nib[k] = active_d[k*NIBBLE_W +: NIBBLE_W];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (k == 0) begin : g_first
      assign w_blank[k] = 1'b0;
    end else begin : g_upper
      assign w_blank[k] = ~|active_d[c_data_w-1:k*NIBBLE_W];
    end
`else
    assign w_blank[k] = 1'b0;
`endif
  end

  sevenseg u_sevenseg (
    .nibble_i (w_nib[idx_d]),
    .seg_o    (w_dec)
  );

  always_comb begin
    w_show     = (state_d == ON) && !w_blank[idx_d];
    seg_d      = w_show ? w_dec : SEG_OFF;
    digit_en_d = w_show ? (c_sel_one << idx_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      shadow_q       <= '0;
      active_q       <= '0;
      pending_q      <= 1'b0;
      active_valid_q <= 1'b0;
      seg_q          <= SEG_OFF;
      digit_en_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      active_valid_q <= active_valid_d;
      seg_q          <= seg_d;
      digit_en_q     <= digit_en_d;
    end
  end

endmodule

`default_nettype wire
